key_run_ctrl: RTL and testbench

// - Upstream control stage for the 0.8 s flowing-LED block: turns one raw push-button into its run-enable (vaild).
// - Synchronises and debounces the button.
// - Short press toggles vaild; long press forces vaild low (stop) and flags it.
// - Sits between board key pin and LED runner; vaild drives the LED runner's vaild input directly.

---
 rtl/key_pkg.sv | 19 +
 rtl/key_sync2.sv | 25 ++
 rtl/key_run_ctrl.sv | 99 +++++++++
 tb/tb_key_run_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the push-button run-control block: FSM encoding and
// default timing constants for a 50 MHz system clock.
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS_DB = 3'd1,
        ST_HELD     = 3'd2,
        ST_LONG     = 3'd3,
        ST_REL_DB   = 3'd4,
        ST_LONG_REL = 3'd5
    } key_state_e;

    // 20 ms debounce and 1 s long-press hold at 50 MHz
    localparam int unsigned DB_CYC_DEF   = 999_999;
    localparam int unsigned LONG_CYC_DEF = 49_999_999;
    localparam int unsigned CNT_W_DEF    = 26;

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchroniser for an asynchronous level; both flops reset to 1 so a
// released (active-low) button is seen right after reset.
module key_sync2 (
    input  logic clk_i,
    input  logic srst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_run_ctrl.sv
// Turns one raw active-low push-button into a run enable: short press toggles
// vaild, long press forces it low. All outputs are registered.
module key_run_ctrl
    import key_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DB_CYC   = DB_CYC_DEF,
    parameter int unsigned LONG_CYC = LONG_CYC_DEF
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic key_in,
    output logic vaild,
    output logic key_press,
    output logic long_press
);

    localparam logic [CNT_W-1:0] DB_LIM   = CNT_W'(DB_CYC);
    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYC);

    logic             key_s;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vaild_q, vaild_d;
    logic             key_press_q, key_press_d;
    logic             long_press_q, long_press_d;

    key_sync2 u_sync (
        .clk_i  (sys_clk),
        .srst_i (rst_n),
        .d_i    (key_in),
        .q_o    (key_s)
    );

    always_ff @(posedge sys_clk) begin
        if (rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            vaild_q      <= 1'b0;
            key_press_q  <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vaild_q      <= vaild_d;
            key_press_q  <= key_press_d;
            long_press_q <= long_press_d;
        end
    end

    // Release is checked before the threshold so a release wins a tie.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!key_s) state_d = ST_PRESS_DB;
            end
            ST_PRESS_DB: begin
                if (key_s)                state_d = ST_IDLE;
                else if (cnt_q == DB_LIM) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (key_s)                  state_d = ST_REL_DB;
                else if (cnt_q == LONG_LIM) state_d = ST_LONG;
            end
            ST_LONG: begin
                cnt_d = '0;
                if (key_s) state_d = ST_LONG_REL;
            end
            ST_REL_DB: begin
                if (!key_s)               state_d = ST_HELD;
                else if (cnt_q == DB_LIM) state_d = ST_IDLE;
            end
            ST_LONG_REL: begin
                if (!key_s)               state_d = ST_LONG;
                else if (cnt_q == DB_LIM) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        key_press_d  = (state_q == ST_REL_DB) && key_s && (cnt_q == DB_LIM);
        long_press_d = (state_q == ST_HELD) && !key_s && (cnt_q == LONG_LIM);
        vaild_d      = vaild_q;
        if (key_press_d)       vaild_d = ~vaild_q;
        else if (long_press_d) vaild_d = 1'b0;
    end

    assign vaild      = vaild_q;
    assign key_press  = key_press_q;
    assign long_press = long_press_q;

endmodule

// File: tb/tb_key_run_ctrl.sv
// Bench for key_run_ctrl with short timings: a run-length model of the
// debounced button is compared against the DUT on every cycle.
module tb_key_run_ctrl;

    localparam int DB   = 3;
    localparam int LONG = 15;
    localparam int CONFIRM = DB + 2;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b1;
    logic key_in  = 1'b0;
    logic vaild;
    logic key_press;
    logic long_press;

    key_run_ctrl #(
        .CNT_W    (26),
        .DB_CYC   (DB),
        .LONG_CYC (LONG)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .vaild      (vaild),
        .key_press  (key_press),
        .long_press (long_press)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: a level change is confirmed after CONFIRM consecutive samples at
    // the new level; a hold counts low samples since the press (re)settled.
    typedef enum {P_UP, P_DOWN, P_LATCHED} phase_e;
    phase_e m_phase;
    logic   m_s1, m_s2, m_last;
    int     m_run, m_hold;
    logic   exp_vaild, exp_kp, exp_lp;

    int kp_cnt = 0, lp_cnt = 0, kp_cyc = 0, lp_cyc = 0;

    always @(posedge sys_clk) begin
        logic ks;
        cyc++;
        if (rst_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_last = 1'b1; m_run = 0; m_hold = 0;
            m_phase = P_UP; exp_vaild = 1'b0; exp_kp = 1'b0; exp_lp = 1'b0;
        end else begin
            ks = m_s2;
            m_s2 = m_s1;
            m_s1 = key_in;
            exp_kp = 1'b0;
            exp_lp = 1'b0;
            if (ks == m_last) m_run++;
            else begin m_run = 1; m_last = ks; end
            case (m_phase)
                P_UP: if (!ks && m_run == CONFIRM) begin
                    m_phase = P_DOWN; m_hold = 0;
                end
                P_DOWN: begin
                    if (ks) begin
                        m_hold = -1;
                        if (m_run == CONFIRM) begin
                            m_phase = P_UP; exp_kp = 1'b1; exp_vaild = !exp_vaild;
                        end
                    end else begin
                        m_hold++;
                        if (m_hold == LONG + 1) begin
                            m_phase = P_LATCHED; exp_lp = 1'b1; exp_vaild = 1'b0;
                        end
                    end
                end
                default: if (ks && m_run == CONFIRM) m_phase = P_UP;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge sys_clk) begin
        if (cyc > 0) begin
            chk("vaild", 32'(vaild), 32'(exp_vaild));
            chk("key_press", 32'(key_press), 32'(exp_kp));
            chk("long_press", 32'(long_press), 32'(exp_lp));
            if (key_press === 1'b1) begin kp_cnt++; kp_cyc = cyc; end
            if (long_press === 1'b1) begin lp_cnt++; lp_cyc = cyc; end
        end
    end

    task automatic hold_key(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic clear_counts();
        kp_cnt = 0;
        lp_cnt = 0;
    endtask

    task automatic report(input string name);
        $display("scenario %s: key_press=%0d long_press=%0d vaild=%0b", name, kp_cnt, lp_cnt, vaild);
    endtask

    int t0;

    initial begin
        // reset with the key held down
        rst_n = 1'b1; key_in = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reset_vaild", 32'(vaild), 32'd0);
        chk("reset_kp", 32'(key_press), 32'd0);
        rst_n = 1'b0;
        clear_counts();
        hold_key(1'b0, 2);
        hold_key(1'b1, 10);
        chk("s1_kp", kp_cnt, 0);
        chk("s1_lp", lp_cnt, 0);
        report("reset");

        // glitch
        clear_counts();
        hold_key(1'b0, 2);
        hold_key(1'b1, 10);
        chk("s2_kp", kp_cnt, 0);
        chk("s2_lp", lp_cnt, 0);
        chk("s2_vaild", 32'(vaild), 32'd0);
        report("glitch");

        // short press twice
        clear_counts();
        hold_key(1'b0, 10);
        t0 = cyc;
        hold_key(1'b1, 10);
        chk("s3a_kp", kp_cnt, 1);
        chk("s3a_latency", kp_cyc - t0, 7);
        chk("s3a_vaild", 32'(vaild), 32'd1);
        report("short_on");
        clear_counts();
        hold_key(1'b0, 10);
        hold_key(1'b1, 10);
        chk("s3b_kp", kp_cnt, 1);
        chk("s3b_vaild", 32'(vaild), 32'd0);
        report("short_off");

        // bounce on release
        clear_counts();
        hold_key(1'b0, 10);
        hold_key(1'b1, 2);
        hold_key(1'b0, 6);
        t0 = cyc;
        hold_key(1'b1, 10);
        chk("s4_kp", kp_cnt, 1);
        chk("s4_latency", kp_cyc - t0, 7);
        chk("s4_vaild", 32'(vaild), 32'd1);
        report("bounce");

        // long press with vaild=1
        clear_counts();
        t0 = cyc;
        hold_key(1'b0, 40);
        chk("s5_lp", lp_cnt, 1);
        chk("s5_latency", lp_cyc - t0, 23);
        chk("s5_vaild_held", 32'(vaild), 32'd0);
        hold_key(1'b1, 10);
        chk("s5_kp", kp_cnt, 0);
        chk("s5_vaild", 32'(vaild), 32'd0);
        report("long");

        // reset while held with vaild=1
        clear_counts();
        hold_key(1'b0, 10);
        hold_key(1'b1, 10);
        chk("s6_vaild_on", 32'(vaild), 32'd1);
        clear_counts();
        hold_key(1'b0, 10);
        rst_n = 1'b1;
        @(negedge sys_clk);
        chk("s6_vaild_rst", 32'(vaild), 32'd0);
        rst_n = 1'b0;
        hold_key(1'b0, 12);
        chk("s6_no_pulse_kp", kp_cnt, 0);
        chk("s6_no_pulse_lp", lp_cnt, 0);
        hold_key(1'b1, 10);
        chk("s6_kp", kp_cnt, 1);
        chk("s6_vaild", 32'(vaild), 32'd1);
        report("mid_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
